// File: rtl/eeprom_arbiter.sv
// Round-robin two-client front end for the EEPROM_WR controller: grants one byte
// request at a time, strobes it out, waits for ACK (or times out) and then observes write recovery.
module eeprom_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TWR_CYC     = 500
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  REQ,
    input  logic [1:0]  WE,
    input  logic [21:0] ADDR_IN,
    input  logic [15:0] WDATA_IN,
    output logic [1:0]  GNT,
    output logic [1:0]  DONE,
    output logic        ERR,
    output logic [7:0]  RDATA,
    output logic        BUSY,
    output logic        EE_WR,
    output logic        EE_RD,
    output logic [10:0] EE_ADDR,
    inout  wire  [7:0]  EE_DATA,
    input  logic        EE_ACK
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RECOVER} state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] TWR_LAST = 16'(TWR_CYC - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [7:0]  rdata_q, rdata_d;

    // Request latched at grant; only meaningful while a transaction is in flight.
    logic        we_q;
    logic [10:0] addr_q;
    logic [7:0]  wdata_q;
    logic        load;
    logic        win;
    logic        on_bus;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        rdata_d = rdata_q;
        load    = 1'b0;
        win     = (REQ == 2'b11) ? ~ptr_q : REQ[1];
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    load       = 1'b1;
                    ptr_d      = win;
                    owner_d    = win;
                    gnt_d[win] = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wr_d    = we_q;
                rd_d    = ~we_q;
                cnt_d   = 16'd0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // ACK takes priority over a timeout landing in the same cycle.
                if (EE_ACK) begin
                    done_d[owner_q] = 1'b1;
                    if (we_q) begin
                        cnt_d   = 16'd0;
                        state_d = RECOVER;
                    end else begin
                        rdata_d = EE_DATA;
                        state_d = IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == TWR_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= 16'd0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (load) begin
            we_q    <= win ? WE[1] : WE[0];
            addr_q  <= win ? ADDR_IN[21:11] : ADDR_IN[10:0];
            wdata_q <= win ? WDATA_IN[15:8] : WDATA_IN[7:0];
        end
    end

    // Address and write byte stay on the bus until ACK because EEPROM_WR samples them late.
    assign on_bus  = (state_q == ISSUE) || (state_q == WAIT_ACK);
    assign EE_ADDR = on_bus ? addr_q : 11'd0;
    assign EE_DATA = (on_bus && we_q) ? wdata_q : 8'bzzzzzzzz;

    assign GNT   = gnt_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign RDATA = rdata_q;
    assign BUSY  = (state_q != IDLE);
    assign EE_WR = wr_q;
    assign EE_RD = rd_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Scoreboard bench for eeprom_arbiter: a transaction-level model predicts grants and
// completions, the bench plays the EEPROM_WR controller, and a monitor checks every GNT/DONE.
module tb_eeprom_arbiter;

    localparam int T   = 48;
    localparam int TWR = 7;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [1:0]  REQ;
    logic [1:0]  WE;
    logic [21:0] ADDR_IN;
    logic [15:0] WDATA_IN;
    wire  [1:0]  GNT;
    wire  [1:0]  DONE;
    wire         ERR;
    wire  [7:0]  RDATA;
    wire         BUSY;
    wire         EE_WR;
    wire         EE_RD;
    wire  [10:0] EE_ADDR;
    wire  [7:0]  EE_DATA;
    logic        EE_ACK;
    logic        tb_drv;
    logic [7:0]  tb_val;

    assign EE_DATA = tb_drv ? tb_val : 8'bzzzzzzzz;

    eeprom_arbiter #(.TIMEOUT_CYC(T), .TWR_CYC(TWR)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .WE(WE), .ADDR_IN(ADDR_IN),
        .WDATA_IN(WDATA_IN), .GNT(GNT), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .BUSY(BUSY), .EE_WR(EE_WR), .EE_RD(EE_RD), .EE_ADDR(EE_ADDR),
        .EE_DATA(EE_DATA), .EE_ACK(EE_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] done;
        logic       err;
        logic [7:0] rdata;
    } done_t;

    done_t      exp_done[$];
    logic [1:0] exp_gnt[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       ptr_m;
    logic [7:0] rdata_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every GNT and DONE pulse must match the next predicted one.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if (GNT != 2'b00) begin
                check("gnt_vs_done", {30'd0, DONE}, 32'd0);
                if (exp_gnt.size() == 0) check("unexpected_gnt", {30'd0, GNT}, 32'd0);
                else check("gnt", {30'd0, GNT}, {30'd0, exp_gnt.pop_front()});
            end
            if (DONE != 2'b00) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", {30'd0, DONE}, 32'd0);
                end else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check("done", {30'd0, DONE}, {30'd0, e.done});
                    check("err", {31'd0, ERR}, {31'd0, e.err});
                    check("rdata", {24'd0, RDATA}, {24'd0, e.rdata});
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, {30'd0, GNT}, 32'd0);
        check({tag, "_done"}, {30'd0, DONE}, 32'd0);
        check({tag, "_ctl"}, {29'd0, ERR, BUSY, EE_WR | EE_RD}, 32'd0);
        check({tag, "_rdata"}, {24'd0, RDATA}, 32'd0);
        check({tag, "_addr"}, {21'd0, EE_ADDR}, 32'd0);
    endtask

    // One full transaction; k = cycles after the strobe cycle at which ACK is given (k >= T: none).
    task automatic do_txn(input logic [1:0] req, input logic [1:0] we, input logic [21:0] addr,
                          input logic [15:0] wd, input int k, input logic [7:0] rv);
        int         w;
        int         lat;
        int         n;
        bit         got;
        bit         bad_strobe;
        bit         bad_hold;
        logic       ew;
        logic       xerr;
        logic [10:0] ea;
        logic [7:0] ed;
        for (int i = 0; i < 200 && BUSY; i++) @(negedge CLK);
        w    = (req == 2'b11) ? (ptr_m ? 0 : 1) : (req[1] ? 1 : 0);
        ptr_m = (w == 1);
        ew   = we[w];
        ea   = (w == 1) ? addr[21:11] : addr[10:0];
        ed   = (w == 1) ? wd[15:8] : wd[7:0];
        xerr = (k >= T);
        if (!ew && !xerr) rdata_m = rv;
        exp_gnt.push_back((w == 1) ? 2'b10 : 2'b01);
        exp_done.push_back('{(w == 1) ? 2'b10 : 2'b01, xerr, rdata_m});
        @(posedge CLK); #1;
        REQ = req; WE = we; ADDR_IN = addr; WDATA_IN = wd;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge CLK);
            got = (GNT != 2'b00);
        end
        check("grant_seen", {31'd0, got}, 32'd1);
        @(posedge CLK); #1;
        REQ = 2'b00; WE = 2'($urandom); ADDR_IN = 22'($urandom); WDATA_IN = 16'($urandom);
        @(negedge CLK);
        check("strobe", {30'd0, EE_WR, EE_RD}, {30'd0, ew, ~ew});
        got = 0; lat = 0; bad_strobe = 0; bad_hold = 0;
        for (int j = 0; j < T + 8 && !got; j++) begin
            if (j > 0 && (EE_WR || EE_RD)) bad_strobe = 1;
            if (EE_ADDR !== ea) bad_hold = 1;
            if (ew && (EE_DATA !== ed)) bad_hold = 1;
            if (j == k) begin
                EE_ACK = 1'b1; tb_drv = ~ew; tb_val = rv;
            end
            @(posedge CLK); #1;
            EE_ACK = 1'b0; tb_drv = 1'b0;
            @(negedge CLK);
            if (DONE != 2'b00) begin
                got = 1; lat = j + 1;
            end
        end
        check("strobe_once", {31'd0, bad_strobe}, 32'd0);
        check("addr_data_hold", {31'd0, bad_hold}, 32'd0);
        check("done_latency", lat, (k < T) ? k + 1 : T);
        check("addr_released", {21'd0, EE_ADDR}, 32'd0);
        n = 0;
        while (BUSY && n < TWR + 10) begin
            n++;
            @(negedge CLK);
        end
        check("recover_len", n, (ew && !xerr) ? TWR : 0);
        if (xerr) begin
            EE_ACK = 1'b1; tb_drv = 1'b1; tb_val = ~rv;
            @(posedge CLK); #1;
            EE_ACK = 1'b0; tb_drv = 1'b0;
            @(negedge CLK);
            check("late_ack_done", {30'd0, DONE}, 32'd0);
            check("late_ack_rdata", {24'd0, RDATA}, {24'd0, rdata_m});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        int r;
        RESET_N = 1'b0; REQ = 2'b00; WE = 2'b00; ADDR_IN = '0; WDATA_IN = '0;
        EE_ACK = 1'b0; tb_drv = 1'b0; tb_val = 8'h00;
        ptr_m = 1'b1; rdata_m = 8'h00;
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(negedge CLK);
        check_reset_outputs("por");

        // Read to make RDATA non-zero, then abandon a client-0 write in WAIT_ACK via reset.
        do_txn(2'b01, 2'b00, 22'h0_0123, 16'h0000, 2, 8'hA7);
        @(posedge CLK); #1;
        REQ = 2'b01; WE = 2'b01; ADDR_IN = 22'h0_0055; WDATA_IN = 16'h00C3;
        ptr_m = 1'b0;
        exp_gnt.push_back(2'b01);
        for (int i = 0; i < 6 && GNT == 2'b00; i++) @(negedge CLK);
        @(posedge CLK); #1 REQ = 2'b00;
        repeat (4) @(posedge CLK);
        #1 RESET_N = 1'b0;
        #1 check_reset_outputs("async_rst");
        tb_drv = 1'b1; tb_val = 8'h3C;
        #1 check("rst_bus_free", {24'd0, EE_DATA}, 32'h3C);
        tb_drv = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check("rst_no_done", {30'd0, DONE}, 32'd0);
        end
        ptr_m = 1'b1; rdata_m = 8'h00;
        @(posedge CLK); #1 RESET_N = 1'b1;
        do_txn(2'b11, 2'b00, 22'h12345, 16'h0000, 0, 8'h11);

        // Directed cases.
        do_txn(2'b01, 2'b01, {11'h000, 11'h3A5}, 16'h00C3, 40, 8'h00);
        do_txn(2'b10, 2'b00, {11'h011, 11'h000}, 16'h0000, 3, 8'h5A);
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, 2'b00, 22'($urandom), 16'($urandom), 0, 8'($urandom));
        do_txn(2'b01, 2'b00, 22'h00077, 16'h0000, T, 8'hE1);
        do_txn(2'b10, 2'b00, 22'h2AA00, 16'h0000, T - 1, 8'h96);
        do_txn(2'b11, 2'b11, 22'($urandom), 16'($urandom), T, 8'h00);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) k = T;
            else if (r == 1) k = T - 1;
            else k = $urandom_range(0, 8);
            do_txn(2'($urandom_range(1, 3)), 2'($urandom), 22'($urandom), 16'($urandom),
                   k, 8'($urandom));
        end

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", exp_done.size() + exp_gnt.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
